// File: rtl/ma_pipe_adder.sv
// ---------------------------------------------------------------------------
// ma_pipe_adder
//   Parametrised pipelined adder whose low APPR_BLKS blocks of BLK bits can
//   switch to an approximate full-adder cell on a per-transaction basis.
//   The carry ripples block to block. A register stage closes every
//   PIPE_BLKS blocks. Both sides use a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operand set is valid
//   in_ready   adder accepts operands this cycle
//   A, B       WIDTH-bit operands
//   Cin        carry into bit 0
//   appr_en    1 = approximate cells in the low APPR_BLKS blocks
//   out_valid  S/Cout hold a valid result
//   out_ready  downstream accepts the result
//   S          WIDTH-bit sum
//   Cout       carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module ma_pipe_adder #(
  parameter int WIDTH     = 32,
  parameter int BLK       = 4,
  parameter int APPR_BLKS = 4,
  parameter int PIPE_BLKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             appr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int NBLK      = WIDTH / BLK;
  localparam int NSTAGE    = (NBLK + PIPE_BLKS - 1) / PIPE_BLKS;
  localparam int STG_BITS  = PIPE_BLKS * BLK;
  localparam int APPR_BITS = APPR_BLKS * BLK;

  // Per-stage registers: operands still to be consumed, partial sum,
  // carry into the next stage, the transaction's mode bit and valid flag.
  logic [WIDTH-1:0] r_a    [NSTAGE];
  logic [WIDTH-1:0] r_b    [NSTAGE];
  logic [WIDTH-1:0] r_s    [NSTAGE];
  logic             r_c    [NSTAGE];
  logic             r_appr [NSTAGE];
  logic             r_v    [NSTAGE];

  // Stage inputs (ports for stage 0, previous register otherwise) and
  // the combinational results of each stage.
  logic [WIDTH-1:0] w_aIn    [NSTAGE];
  logic [WIDTH-1:0] w_bIn    [NSTAGE];
  logic [WIDTH-1:0] w_sIn    [NSTAGE];
  logic             w_cIn    [NSTAGE];
  logic             w_apprIn [NSTAGE];
  logic [WIDTH-1:0] w_sOut   [NSTAGE];
  logic             w_cOut   [NSTAGE];
  logic             w_stall;

  // The only way to hold data is a valid result that downstream refuses,
  // so one stall signal freezes the whole pipe.
  assign w_stall   = r_v[NSTAGE-1] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_v[NSTAGE-1];
  assign S         = r_s[NSTAGE-1];
  assign Cout      = r_c[NSTAGE-1];

  // Route each stage's operands. A/B are passed on at full width. The bits
  // that earlier stages already consumed are simply never read again.
  always_comb begin
    w_aIn[0]    = A;
    w_bIn[0]    = B;
    w_sIn[0]    = '0;
    w_cIn[0]    = Cin;
    w_apprIn[0] = appr_en;
    for (int s = 1; s < NSTAGE; s++) begin
      w_aIn[s]    = r_a[s-1];
      w_bIn[s]    = r_b[s-1];
      w_sIn[s]    = r_s[s-1];
      w_cIn[s]    = r_c[s-1];
      w_apprIn[s] = r_appr[s-1];
    end
  end

  // Each stage ripples through its own bit range and leaves the other sum
  // bits untouched. The last stage's range runs past WIDTH when PIPE_BLKS
  // does not divide the block count, so it absorbs the leftover blocks.
  // The approximate cell copies A_i into the carry, which breaks the carry
  // chain inside the approximate region.
  always_comb begin
    logic w_carry;
    for (int s = 0; s < NSTAGE; s++) begin
      w_carry   = w_cIn[s];
      w_sOut[s] = w_sIn[s];
      for (int i = 0; i < WIDTH; i++) begin
        if ((i >= s * STG_BITS) && (i < (s + 1) * STG_BITS)) begin
          if (w_apprIn[s] && (i < APPR_BITS)) begin
            w_sOut[s][i] = (~w_aIn[s][i] & w_bIn[s][i]) | (w_aIn[s][i] & w_carry);
            w_carry      = w_aIn[s][i];
          end else begin
            w_sOut[s][i] = w_aIn[s][i] ^ w_bIn[s][i] ^ w_carry;
            w_carry      = (w_aIn[s][i] & w_bIn[s][i]) | (w_aIn[s][i] & w_carry) |
                           (w_bIn[s][i] & w_carry);
          end
        end
      end
      w_cOut[s] = w_carry;
    end
  end

  // All stages advance together when not stalled. Data registers load every
  // advancing cycle. Only the valid bits decide whether the contents mean
  // anything, and a bubble therefore moves down the pipe like a transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSTAGE; s++) begin
        r_a[s]    <= '0;
        r_b[s]    <= '0;
        r_s[s]    <= '0;
        r_c[s]    <= 1'b0;
        r_appr[s] <= 1'b0;
        r_v[s]    <= 1'b0;
      end
    end else if (!w_stall) begin
      r_v[0] <= in_valid;
      for (int s = 1; s < NSTAGE; s++) begin
        r_v[s] <= r_v[s-1];
      end
      for (int s = 0; s < NSTAGE; s++) begin
        r_a[s]    <= w_aIn[s];
        r_b[s]    <= w_bIn[s];
        r_s[s]    <= w_sOut[s];
        r_c[s]    <= w_cOut[s];
        r_appr[s] <= w_apprIn[s];
      end
    end
  end

endmodule

// File: tb/tb_ma_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_ma_pipe_adder
//   Directed self-checking bench for ma_pipe_adder at default parameters
//   (32-bit, 4-bit blocks, low 4 blocks approximable, 4 pipeline stages).
// ---------------------------------------------------------------------------
module tb_ma_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        appr_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        Cout;

  int cmpCount = 0;
  int errCount = 0;

  logic [31:0] vecA    [8];
  logic [31:0] vecB    [8];
  logic        vecCin  [8];
  logic        vecAppr [8];
  logic [31:0] expS    [8];
  logic        expC    [8];

  ma_pipe_adder #(
    .WIDTH     (32),
    .BLK       (4),
    .APPR_BLKS (4),
    .PIPE_BLKS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .appr_en   (appr_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout)
  );

  // Free-running 10 ns clock; inputs change and outputs are sampled on the
  // falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    cmpCount++;
    if (got !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference: low 16 bits with the approximate cell when appr is set,
  // everything else by plain integer addition.
  function automatic logic [32:0] refAdd(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic appr);
    logic [31:0] s;
    logic [16:0] hi;
    logic        c;
    if (!appr) begin
      return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    end
    c = cin;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      s[i] = (~a[i] & b[i]) | (a[i] & c);
      c    = a[i];
    end
    hi       = {1'b0, a[31:16]} + {1'b0, b[31:16]} + {16'd0, c};
    s[31:16] = hi[15:0];
    return {hi[16], s};
  endfunction

  // Present one operand set for exactly one accepting edge; returns on the
  // falling edge after the accept.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic appr);
    A        = a;
    B        = b;
    Cin      = cin;
    appr_en  = appr;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Single transaction with latency check: invalid after accept edges
  // k..k+2, valid with the result after k+3, gone again after k+4.
  task automatic runSingle(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic appr,
                           input logic [31:0] sExp, input logic cExp);
    applyStimulus(a, b, cin, appr);
    checkOutput({tag, "_v0"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    checkOutput({tag, "_v1"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    checkOutput({tag, "_v2"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, "_S"}, {32'd0, S}, {32'd0, sExp});
    checkOutput({tag, "_Cout"}, {63'd0, Cout}, {63'd0, cExp});
    @(negedge clk);
    checkOutput({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
  endtask

  // Random operands, alternating mode, expected values from refAdd.
  task automatic fillVectors();
    logic [32:0] r;
    for (int j = 0; j < 8; j++) begin
      vecA[j]    = $urandom;
      vecB[j]    = $urandom;
      vecCin[j]  = 1'($urandom_range(0, 1));
      vecAppr[j] = (j % 2) == 1;
      r          = refAdd(vecA[j], vecB[j], vecCin[j], vecAppr[j]);
      expS[j]    = r[31:0];
      expC[j]    = r[32];
    end
  endtask

  // Stream n vectors, optionally refusing the first result for stallLen
  // cycles. Results are checked in order against the expected table; the
  // first must appear 4 falling edges after the first drive, and the run
  // must have no gaps other than the stall.
  task automatic runStream(input string tag, input int n, input int stallLen);
    int tx = 0;
    int rx = 0;
    int t = 0;
    int firstOut = -1;
    int lastOut = -1;
    int stallLeft = 0;
    while (rx < n && t < 60) begin
      if (out_valid) begin
        checkOutput({tag, "_S"}, {32'd0, S}, {32'd0, expS[rx]});
        checkOutput({tag, "_Cout"}, {63'd0, Cout}, {63'd0, expC[rx]});
        if (firstOut < 0) begin
          firstOut  = t;
          stallLeft = stallLen;
        end
      end
      out_ready = (stallLeft == 0);
      if (stallLeft > 0) stallLeft--;
      #1;
      if (!out_ready) begin
        checkOutput({tag, "_inReady"}, {63'd0, in_ready}, 64'd0);
        checkOutput({tag, "_holdV"}, {63'd0, out_valid}, 64'd1);
      end
      if (out_valid && out_ready) begin
        rx++;
        lastOut = t;
      end
      if (tx < n) begin
        A        = vecA[tx];
        B        = vecB[tx];
        Cin      = vecCin[tx];
        appr_en  = vecAppr[tx];
        in_valid = 1'b1;
        if (in_ready) tx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput({tag, "_count"}, 64'(rx), 64'(n));
    checkOutput({tag, "_first"}, 64'(firstOut), 64'd4);
    checkOutput({tag, "_span"}, 64'(lastOut - firstOut), 64'(n - 1 + stallLen));
    checkOutput({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
  endtask

  // Four accepts so the oldest is already at the output, then an
  // asynchronous reset between edges, then a fresh transaction.
  task automatic runResetMidFlight();
    for (int j = 0; j < 4; j++) begin
      A        = vecA[j];
      B        = vecB[j];
      Cin      = vecCin[j];
      appr_en  = vecAppr[j];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("rstPre_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("rstPre_S", {32'd0, S}, {32'd0, expS[0]});
    #2 rst = 1'b1;
    #1;
    checkOutput("rstAsync_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rstAsync_S", {32'd0, S}, 64'd0);
    checkOutput("rstAsync_Cout", {63'd0, Cout}, 64'd0);
    checkOutput("rstAsync_inReady", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    runSingle("postRst", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_000D, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    appr_en   = 1'b0;
    #1;
    checkOutput("reset_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_S", {32'd0, S}, 64'd0);
    checkOutput("reset_Cout", {63'd0, Cout}, 64'd0);
    checkOutput("reset_inReady", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed single transactions");
    runSingle("exactWrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    runSingle("apprErr",    32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0002, 1'b0);
    runSingle("exact3",     32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0003, 1'b0);
    runSingle("apprKill",   32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    runSingle("exact1p1",   32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0);
    runSingle("apprHigh",   32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 32'h0002_0000, 1'b0);
    runSingle("apprBound",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_FFFE, 1'b1);
    runSingle("exactOnes",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    runSingle("apprCin",    32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0001, 1'b0);
    runSingle("exactCin",   32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0002, 1'b0);

    $display("[TB] back-to-back stream, alternating mode");
    fillVectors();
    runStream("stream", 8, 0);

    $display("[TB] backpressure stream");
    fillVectors();
    runStream("bp", 4, 3);

    $display("[TB] reset mid-flight");
    fillVectors();
    runResetMidFlight();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
